// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: program counter plus the IF/ID pipeline register.
// Flags misaligned or out-of-range fetches and counts accepted instructions.
package rv32i_pkg;
  parameter int DPW   = 32;
  parameter int Depth = 1024;
endpackage

module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [DPW-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [DPW-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           StallF,
  input  logic           StallD,
  input  logic           FlushD,
  input  logic           PCSrcE,
  input  logic [DPW-1:0] PCTargetE,
  input  logic [DPW-1:0] InstrF,
  output logic [DPW-1:0] PCF,
  output logic [DPW-1:0] InstrD,
  output logic [DPW-1:0] PCD,
  output logic [DPW-1:0] PCPlus4D,
  output logic           ValidD,
  output logic           FaultD,
  output logic [31:0]    FetchCount
);

  localparam logic [DPW-1:0] LAST_ADDR = DPW'(Depth - 4);

  logic [DPW-1:0] pc_plus4_f;
  logic           fault_f;
  logic           capture;

  assign pc_plus4_f = PCF + DPW'(4);
  assign fault_f    = (PCF[1:0] != 2'b00) || (PCF > LAST_ADDR);
  assign capture    = !FlushD && !StallD;

  // Redirect outranks StallF so a taken branch is never lost.
  always_ff @(posedge clk) begin
    if (reset)
      PCF <= RESET_PC;
    else if (PCSrcE)
      PCF <= PCTargetE;
    else if (!StallF)
      PCF <= pc_plus4_f;
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
      FaultD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= fault_f ? NOP_INSTR : InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
      FaultD   <= fault_f;
    end
  end

  // Faulting fetches still occupy IF/ID, so they are counted too.
  always_ff @(posedge clk) begin
    if (reset)
      FetchCount <= '0;
    else if (capture && (FetchCount != 32'hFFFF_FFFF))
      FetchCount <= FetchCount + 32'd1;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction inserted into the IF/ID register.
REQ-003 Width parameters DPW and Depth SHALL come from rv32i_pkg; no local redefinition.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 StallF  input  1  hold PC.
REQ-007 StallD  input  1  hold IF/ID register.
REQ-008 FlushD  input  1  insert bubble into IF/ID register.
REQ-009 PCSrcE  input  1  taken branch/jump redirect from execute.
REQ-010 PCTargetE  input  DPW  redirect target address.
REQ-011 InstrF  input  DPW  instruction returned combinationally by instruction memory for PCF.
REQ-012 PCF  output  DPW  current fetch address, driven to instruction memory.
REQ-013 InstrD, PCD, PCPlus4D  output  DPW each  decode-stage instruction, its PC, and its PC+4.
REQ-014 ValidD  output  1  IF/ID holds a real fetched instruction.
REQ-015 FaultD  output  1  IF/ID instruction came from a misaligned or out-of-range PC.
REQ-016 FetchCount  output  32  count of instructions accepted into IF/ID.

Function
REQ-017 PC next-state priority: reset -> RESET_PC; else PCSrcE -> PCTargetE; else StallF -> hold; else PCF+4, modulo 2^DPW (wrap, no carry out).
REQ-018 PCSrcE SHALL override StallF in the same cycle; a redirect is never lost.
REQ-019 Fetch fault (combinational, fault_F) SHALL be asserted when PCF[1:0] != 0 or PCF > Depth-4.
REQ-020 IF/ID priority: reset or FlushD -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FaultD=0; else StallD -> hold all; else capture.
REQ-021 Capture: PCD=PCF, PCPlus4D=PCF+4 (mod 2^DPW), ValidD=1, FaultD=fault_F, InstrD=InstrF if !fault_F, else NOP_INSTR.
REQ-022 FlushD SHALL override StallD in the same cycle.
REQ-023 Latency: instruction at PCF appears on InstrD on the next rising edge (1 cycle), when neither stalled nor flushed.
REQ-024 FetchCount SHALL increment by 1 on each capture (REQ-021) and saturate at 32'hFFFF_FFFF; it holds on stall, flush and fault-free bubbles.
REQ-025 StallF=0 with StallD=1 is legal; the captured word is dropped and not replayed; hazard logic is responsible for the pairing.
REQ-026 No combinational path from any input to PCF; PCF is a register output.

Reset
REQ-027 On a rising edge with reset=1: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FaultD=0, FetchCount=0.
REQ-028 Reset SHALL override stall, flush and redirect when asserted mid-operation.
REQ-029 First capture occurs on the first edge after reset deasserts, using PCF=RESET_PC.

Verification
REQ-030 Reset 2 cycles, then free-run with memory model (word@0=0x00022203, @4=0x0042A283) -> PCF 0,4,8,12; InstrD=0x00022203, PCD=0 one cycle after release; next InstrD=0x0042A283; FetchCount=2.
REQ-031 StallF=StallD=1 for 2 cycles while PCF=8 -> PCF holds 8, InstrD holds 0x0042A283, PCD=4, FetchCount unchanged.
REQ-032 PCSrcE=1, PCTargetE=0x10, FlushD=1 -> next edge PCF=0x10, InstrD=0x00000013, ValidD=0; following edge InstrD=0x00428333, PCD=0x10, PCPlus4D=0x14.
REQ-033 PCSrcE=1 and StallF=1 in same cycle, PCTargetE=0x18 -> PCF=0x18 next edge.
REQ-034 Redirect to 0x0A, then redirect to Depth -> each following capture: FaultD=1, ValidD=1, InstrD=0x00000013, PCD=0x0A / Depth.
REQ-035 reset=1 asserted with StallD=1, FlushD=0, PCSrcE=1 mid-stream -> all REQ-027 values next edge, PCF=RESET_PC, not PCTargetE.
